// File: rtl/sram_req_ctrl_256x32_if.sv
// sram_req_ctrl_256x32_if: request/response channel plus SRAM macro pins of the 256x32 controller
// Ports: req_* request channel, rsp_* response channel, init_done sweep status,
//        CEN/WEN/OEN/ADR/DI macro drive, DOUT macro read data.
interface sram_req_ctrl_256x32_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        CEN;
  logic [3:0]  WEN;
  logic        OEN;
  logic [7:0]  ADR;
  logic [31:0] DI;
  logic [31:0] DOUT;
  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready, DOUT,
    output req_ready, rsp_valid, rsp_rdata, init_done, CEN, WEN, OEN, ADR, DI
  );
  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready, DOUT,
    input  req_ready, rsp_valid, rsp_rdata, init_done, CEN, WEN, OEN, ADR, DI
  );
endinterface

// File: rtl/sram_req_ctrl_256x32.sv
// sram_req_ctrl_256x32: valid/ready front end for the 256x32 byte-writable SRAM macro with zero-fill sweep
// Ports: CK clock, RST sync active-high reset, bus (slave) carrying request/response channels,
//        init_done and the macro pins CEN/WEN/OEN/ADR/DI/DOUT.
module sram_req_ctrl_256x32 #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic CK,
  input logic RST,
  sram_req_ctrl_256x32_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t      r_state;
  logic [7:0]  r_sweep;
  logic [7:0]  r_adr;
  logic [31:0] r_di;
  logic        r_init_done;
  logic        r_inflight;
  logic [1:0]  r_cnt;
  logic        r_wp;
  logic        r_rp;
  logic [31:0] r_mem [2];
  logic        w_init;
  logic        w_rsp_valid;
  logic        w_pop;
  logic [1:0]  w_occ;
  logic        w_ready;
  logic        w_acc;
  logic        w_rd;
  logic        w_wr;
  logic [7:0]  w_adr;
  logic [31:0] w_di;
  assign w_init      = r_state == INIT;
  assign w_rsp_valid = r_cnt != 2'd0;
  assign w_pop       = w_rsp_valid & bus.rsp_ready;
  // Slots that will be occupied next cycle if nothing new is accepted; a read needs one free.
  assign w_occ       = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_ready     = r_init_done & (bus.req_we | (w_occ < 2'd2));
  assign w_acc       = bus.req_valid & w_ready;
  assign w_rd        = w_acc & ~bus.req_we;
  // A write with no byte enabled is consumed without touching the macro.
  assign w_wr        = w_acc & bus.req_we & (|bus.req_wstrb);
  assign w_adr       = w_init ? r_sweep : (w_rd | w_wr) ? bus.req_addr : r_adr;
  assign w_di        = w_init ? 32'h0 : w_wr ? bus.req_wdata : r_di;
  assign bus.CEN       = w_init ? ~CLEAR_ON_RESET : ~(w_rd | w_wr);
  assign bus.WEN       = w_init ? {4{~CLEAR_ON_RESET}} : w_wr ? ~bus.req_wstrb : 4'hF;
  assign bus.ADR       = w_adr;
  assign bus.DI        = w_di;
  assign bus.OEN       = ~r_inflight;
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_mem[r_rp];
  assign bus.init_done = r_init_done;
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state     <= INIT;
      r_sweep     <= 8'h0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
      r_cnt       <= 2'd0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_adr       <= 8'h0;
      r_di        <= 32'h0;
    end else begin
      r_adr      <= w_adr;
      r_di       <= w_di;
      r_inflight <= w_rd;
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_init) begin
        r_sweep <= r_sweep + 8'd1;
        if (!CLEAR_ON_RESET || r_sweep == 8'hFF) begin
          r_state     <= RUN;
          r_init_done <= 1'b1;
        end
      end
      if (r_inflight) begin
        r_mem[r_wp] <= bus.DOUT;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
    end
  end
endmodule

// File: tb/tb_sram_req_ctrl_256x32.sv
// tb_sram_req_ctrl_256x32: directed bench with a behavioural 256x32 macro model
module tb_sram_req_ctrl_256x32;
  logic CK;
  logic RST;
  int n_cmp;
  int n_err;
  logic [31:0] mem [256];
  sram_req_ctrl_256x32_if bus();
  sram_req_ctrl_256x32_if bus0();
  sram_req_ctrl_256x32 #(.CLEAR_ON_RESET(1'b1)) dut (.CK(CK), .RST(RST), .bus(bus));
  sram_req_ctrl_256x32 #(.CLEAR_ON_RESET(1'b0)) dut0 (.CK(CK), .RST(RST), .bus(bus0));
  assign bus0.req_valid = 1'b0;
  assign bus0.req_we    = 1'b0;
  assign bus0.req_addr  = 8'h0;
  assign bus0.req_wstrb = 4'h0;
  assign bus0.req_wdata = 32'h0;
  assign bus0.rsp_ready = 1'b0;
  assign bus0.DOUT      = 32'h0;
  initial CK = 1'b0;
  always #5 CK = ~CK;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;
  always @(posedge CK) begin
    if (!bus.CEN) begin
      if (&bus.WEN) bus.DOUT <= mem[bus.ADR];
      else for (int b = 0; b < 4; b++) if (!bus.WEN[b]) mem[bus.ADR][8*b +: 8] <= bus.DI[8*b +: 8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CK);
    #1;
  endtask
  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wstrb = s;
    bus.req_wdata = d;
    #1;
  endtask
  initial begin
    int n;
    int stale;
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    repeat (2) step();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_oen", bus.OEN, 1);
    chk("rst_adr", bus.ADR, 0);
    chk("rst_di", bus.DI, 0);
    chk("rst_cen", bus.CEN, 0);
    chk("rst_wen", bus.WEN, 4'h0);
    chk("rst0_cen", bus0.CEN, 1);
    chk("rst0_wen", bus0.WEN, 4'hF);
    RST = 1'b0;
    #1;
    chk("c0_init_done0", bus0.init_done, 0);
    step();
    chk("c1_init_done0", bus0.init_done, 1);
    chk("c1_adr", bus.ADR, 8'd1);
    repeat (254) step();
    chk("c255_adr", bus.ADR, 8'd255);
    chk("c255_init_done", bus.init_done, 0);
    chk("c255_req_ready", bus.req_ready, 0);
    step();
    chk("c256_init_done", bus.init_done, 1);
    chk("c256_cen_idle", bus.CEN, 1);
    // sweep result
    bus.rsp_ready = 1'b1;
    drive(1, 0, 8'd0, 4'h0, 32'h0);
    chk("sw_rd_ready", bus.req_ready, 1);
    chk("sw_rd_cen", bus.CEN, 0);
    chk("sw_rd_wen", bus.WEN, 4'hF);
    step();
    drive(1, 0, 8'd128, 4'h0, 32'h0);
    chk("sw_oen", bus.OEN, 0);
    step();
    drive(1, 0, 8'd255, 4'h0, 32'h0);
    chk("sw_v0", bus.rsp_valid, 1);
    chk("sw_d0", bus.rsp_rdata, 32'h0);
    step();
    drive(0, 0, 8'd0, 4'h0, 32'h0);
    chk("sw_v128", bus.rsp_valid, 1);
    chk("sw_d128", bus.rsp_rdata, 32'h0);
    step();
    chk("sw_v255", bus.rsp_valid, 1);
    chk("sw_d255", bus.rsp_rdata, 32'h0);
    step();
    chk("sw_empty", bus.rsp_valid, 0);
    // byte mask
    drive(1, 1, 8'h10, 4'hF, 32'hDEADBEEF);
    chk("bm_wen_full", bus.WEN, 4'h0);
    chk("bm_adr", bus.ADR, 8'h10);
    step();
    drive(1, 1, 8'h10, 4'b0001, 32'h00000055);
    chk("bm_wen_byte", bus.WEN, 4'b1110);
    chk("bm_di", bus.DI, 32'h00000055);
    step();
    drive(1, 0, 8'h10, 4'h0, 32'h0);
    step();
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    chk("bm_adr_hold", bus.ADR, 8'h10);
    step();
    chk("bm_valid", bus.rsp_valid, 1);
    chk("bm_data", bus.rsp_rdata, 32'hDEADBE55);
    step();
    // back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(i), 4'hF, 32'(i));
      chk("b2b_wr_ready", bus.req_ready, 1);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 8'(i), 4'h0, 32'h0);
      else drive(0, 0, 8'h0, 4'h0, 32'h0);
      if (i < 4) chk("b2b_rd_ready", bus.req_ready, 1);
      if (i >= 2) begin
        chk("b2b_valid", bus.rsp_valid, 1);
        chk("b2b_data", bus.rsp_rdata, 32'(i - 2));
      end
      step();
    end
    // backpressure
    bus.rsp_ready = 1'b0;
    drive(1, 0, 8'd1, 4'h0, 32'h0);
    chk("bp_r1_ready", bus.req_ready, 1);
    step();
    drive(1, 0, 8'd2, 4'h0, 32'h0);
    chk("bp_r2_ready", bus.req_ready, 1);
    step();
    drive(1, 0, 8'd3, 4'h0, 32'h0);
    chk("bp_r3_stall", bus.req_ready, 0);
    chk("bp_r3_cen", bus.CEN, 1);
    drive(1, 1, 8'd20, 4'hF, 32'hCAFEF00D);
    chk("bp_wr_ready", bus.req_ready, 1);
    chk("bp_wr_cen", bus.CEN, 0);
    step();
    drive(1, 0, 8'd3, 4'h0, 32'h0);
    chk("bp_full_stall", bus.req_ready, 0);
    chk("bp_full_head", bus.rsp_rdata, 32'd1);
    step();
    chk("bp_still_stall", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_pop_accept", bus.req_ready, 1);
    chk("bp_d1", bus.rsp_rdata, 32'd1);
    step();
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    chk("bp_v2", bus.rsp_valid, 1);
    chk("bp_d2", bus.rsp_rdata, 32'd2);
    step();
    chk("bp_v3", bus.rsp_valid, 1);
    chk("bp_d3", bus.rsp_rdata, 32'd3);
    step();
    chk("bp_drained", bus.rsp_valid, 0);
    // zero strobe
    drive(1, 1, 8'd5, 4'hF, 32'h12345678);
    step();
    drive(1, 1, 8'd5, 4'h0, 32'hFFFFFFFF);
    chk("zs_ready", bus.req_ready, 1);
    chk("zs_cen", bus.CEN, 1);
    step();
    drive(1, 0, 8'd5, 4'h0, 32'h0);
    step();
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    step();
    chk("zs_valid", bus.rsp_valid, 1);
    chk("zs_data", bus.rsp_rdata, 32'h12345678);
    step();
    // reset mid-operation
    bus.rsp_ready = 1'b0;
    drive(1, 0, 8'd0, 4'h0, 32'h0);
    step();
    drive(1, 0, 8'd1, 4'h0, 32'h0);
    step();
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    chk("mr_valid_pre", bus.rsp_valid, 1);
    chk("mr_oen_pre", bus.OEN, 0);
    RST = 1'b1;
    step();
    chk("mr_valid", bus.rsp_valid, 0);
    chk("mr_init_done", bus.init_done, 0);
    chk("mr_adr", bus.ADR, 0);
    chk("mr_cen", bus.CEN, 0);
    chk("mr_oen", bus.OEN, 1);
    RST = 1'b0;
    bus.rsp_ready = 1'b1;
    n = 0;
    stale = 0;
    while (!bus.init_done && n < 300) begin
      if (bus.rsp_valid) stale++;
      step();
      n++;
    end
    chk("mr_sweep_len", n, 256);
    chk("mr_no_stale", stale, 0);
    drive(1, 0, 8'h10, 4'h0, 32'h0);
    step();
    drive(0, 0, 8'h0, 4'h0, 32'h0);
    step();
    chk("mr_reswept", bus.rsp_rdata, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_req_ctrl_256x32.md
# sram_req_ctrl_256x32

Initiator-side controller for the 256x32 byte-writable single-port SRAM macro (CK/CEN/WEN/OEN/ADR/DI/DOUT interface) used by the ethmac buffer memories. It converts a valid/ready request channel into macro access cycles and returns read data on a back-pressurable valid/ready response channel through a 2-entry response FIFO. After reset it optionally sweeps the whole array to zero before accepting traffic.

## Interface
- CLEAR_ON_RESET, default 1: 1 = zero-fill all 256 words after reset; 0 = skip the sweep.
- CK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready are both high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  8  word address.
- req_wstrb  in  4  active-high byte enables; bit i covers wdata[8i+7:8i].
- req_wdata  in  32  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes data when rsp_valid & rsp_ready are both high.
- rsp_rdata  out  32  read data, in request order.
- init_done  out  1  sweep complete; traffic allowed.
- CEN  out  1  macro chip enable, active-low.
- WEN  out  4  macro per-byte write enable, active-low.
- OEN  out  1  macro output enable, active-low.
- ADR  out  8  macro address.
- DI  out  32  macro write data.
- DOUT  in  32  macro read data, valid in the cycle after the read access edge.

## Operation
- States: INIT, RUN. RST forces INIT with sweep address 0. If CLEAR_ON_RESET=0, INIT lasts exactly one cycle.
- INIT: each cycle CEN=0, WEN=4'h0, ADR=sweep address, DI=0. Sweep address increments from 0 to 255. At the edge that writes address 255, move to RUN and set init_done=1. req_ready=0 throughout INIT.
- RUN, macro drive (combinational from the accepted handshake):
  - Write with req_wstrb≠0: CEN=0, WEN=~req_wstrb, ADR=req_addr, DI=req_wdata.
  - Write with req_wstrb=0: accepted, but no access is made (CEN=1).
  - Read: CEN=0, WEN=4'hF, ADR=req_addr.
  - No handshake: CEN=1, WEN=4'hF. ADR and DI hold their previous values.
- Read pipeline: a one-bit in-flight flag is set at the read access edge. During the next cycle OEN=0 and DOUT is pushed into the FIFO at that cycle's end edge. OEN=1 at all other times.
- Credit rule: reads may be accepted only if (fifo_count + inflight − pop) < 2, where pop = rsp_valid & rsp_ready. Writes ignore credits. req_ready = init_done & (req_we | credit_ok).
- FIFO: 2 entries, in-order. rsp_valid = (fifo_count ≠ 0). rsp_rdata = head entry. A push and a pop in the same cycle leave the count unchanged.
- Mid-operation RST:
  - Discards the FIFO and in-flight read.
  - Returns to INIT and restarts the sweep at address 0.
  - Does not undo partially swept memory contents.

## Timing
- Reset values (in the cycle after the RST edge): rsp_valid=0, init_done=0, req_ready=0, fifo_count=0, inflight=0, OEN=1, ADR=0, DI=0.
  - CLEAR_ON_RESET=1: CEN=0, WEN=4'h0 (sweep begins).
  - CLEAR_ON_RESET=0: CEN=1, WEN=4'hF.
- Sweep: 256 access cycles. With RST deasserted before edge 0, init_done=1 from cycle 256.
- Read latency: request accepted in cycle N → rsp_valid=1 in cycle N+2.
- Throughput: with rsp_ready held high, one read per cycle is sustained. With rsp_ready low, at most 2 reads are outstanding, after which read req_ready=0.
- Writes take effect at the accept edge. A read to the same address accepted one cycle later returns the new data.

## Test plan
- Sweep: CLEAR_ON_RESET=1, release RST → init_done rises at cycle 256; reads of addresses 0, 128 and 255 return 32'h0.
- Byte mask:
  - Write addr 8'h10 = 32'hDEADBEEF with strb 4'hF.
  - Then write 32'h00000055 with strb 4'b0001.
  - Read addr 8'h10 → 32'hDEADBE55.
  - WEN during the second write = 4'b1110.
- Back-to-back reads: write addrs 0–3 with values 0–3, then issue 4 consecutive reads with rsp_ready=1 → req_ready stays high, rsp_rdata = 0,1,2,3 in cycles N+2..N+5.
- Backpressure:
  - rsp_ready=0, issue 3 reads → third read stalls (req_ready=0) and a write in the same cycle is still accepted.
  - Raise rsp_ready → data drains in order and the third read is accepted in the same cycle as the first pop.
- Zero strobe: write with strb 4'h0 to addr 5 holding 32'h12345678 → CEN stays 1 that cycle; read returns 32'h12345678.
- Reset mid-operation: assert RST while rsp_valid=1 and a read is in flight → next cycle rsp_valid=0, init_done=0; the sweep restarts at ADR=0 and no stale response ever appears.
